// File: rtl/msfsm_sched_pkg.sv
// msfsm_sched_pkg: shared types and constants for the MSFSM event scheduler
package msfsm_sched_pkg;
  typedef enum logic {CH_RI, CH_AI} chan_idx_e;
  typedef struct packed {
    logic pend_plus;
    logic pend_minus;
    logic phase;
  } token_t;
  localparam int NUM_CH = 2;
endpackage

// File: rtl/msfsm_level_chan.sv
// msfsm_level_chan: level synchroniser, edge detect and PLUS/MINUS token register for one channel
module msfsm_level_chan
  import msfsm_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic lvl_i,
  input  logic grant_i,
  output logic ready_o,
  output logic pol_o,
  output logic ovf_o
);
  logic lvl_s, prev_q, rise, fall, keep_p, keep_m;
  token_t tok_q, tok_d;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign lvl_s = lvl_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk)
      if (reset) sync_q <= '0;
      else begin
        sync_q[0] <= lvl_i;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    assign lvl_s = sync_q[SYNC_STAGES-1];
  end
  always_comb begin
    rise = lvl_s & ~prev_q;
    fall = ~lvl_s & prev_q;
    ready_o = tok_q.pend_plus | tok_q.pend_minus;
    pol_o = tok_q.pend_plus & (~tok_q.pend_minus | tok_q.phase);
    keep_p = tok_q.pend_plus & ~(grant_i & pol_o);
    keep_m = tok_q.pend_minus & ~(grant_i & ~pol_o);
    ovf_o = (rise & tok_q.pend_plus) | (fall & tok_q.pend_minus);
    tok_d.pend_plus = keep_p | (rise & ~tok_q.pend_plus);
    tok_d.pend_minus = keep_m | (fall & ~tok_q.pend_minus);
    tok_d.phase = (keep_p & keep_m) ? tok_q.phase : keep_p ? 1'b1 : keep_m ? 1'b0 : rise & ~tok_q.pend_plus;
  end
  always_ff @(posedge clk)
    if (reset) begin
      prev_q <= 1'b0;
      tok_q <= '0;
    end else begin
      prev_q <= lvl_s;
      tok_q <= tok_d;
    end
endmodule

// File: rtl/msfsm_event_scheduler.sv
// msfsm_event_scheduler: level-to-event and event-to-level interface with round-robin issue, error flags and watchdog
module msfsm_event_scheduler
  import msfsm_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ISSUE = 1,
  parameter int TIMEOUT = 1023,
  parameter int CW = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic Ri,
  input  logic Ai,
  output logic Ri_PLUS,
  output logic Ri_MINUS,
  output logic Ai_PLUS,
  output logic Ai_MINUS,
  input  logic Ro_PLUS,
  input  logic Ro_MINUS,
  input  logic Ao_PLUS,
  input  logic Ao_MINUS,
  output logic Ro,
  output logic Ao,
  output logic err_ovf,
  output logic err_out,
  output logic stall
);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  logic [NUM_CH-1:0] lvl, rdy, pol, ovf, gnt;
  logic [3:0] pls_q, pls_d;
  chan_idx_e rr_q, rr_d;
  logic ro_q, ro_d, ao_q, ao_d, ovf_q, ovf_d, out_q, out_d, evt;
  logic [CW-1:0] wd_q, wd_d;
  assign lvl = {Ai, Ri};
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    msfsm_level_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clk(clk),
      .reset(reset),
      .lvl_i(lvl[i]),
      .grant_i(gnt[i]),
      .ready_o(rdy[i]),
      .pol_o(pol[i]),
      .ovf_o(ovf[i])
    );
  end
  always_comb begin
    gnt = (MAX_ISSUE == 1 && &rdy) ? ((rr_q == CH_AI) ? 2'b01 : 2'b10) : rdy;
    rr_d = |gnt ? chan_idx_e'(~rr_q) : rr_q;
    pls_d = {gnt[1] & ~pol[1], gnt[1] & pol[1], gnt[0] & ~pol[0], gnt[0] & pol[0]};
    ro_d = (Ro_PLUS ^ Ro_MINUS) ? Ro_PLUS : ro_q;
    ao_d = (Ao_PLUS ^ Ao_MINUS) ? Ao_PLUS : ao_q;
    out_d = out_q | (Ro_PLUS & (Ro_MINUS | ro_q)) | (Ro_MINUS & ~ro_q)
                  | (Ao_PLUS & (Ao_MINUS | ao_q)) | (Ao_MINUS & ~ao_q);
    ovf_d = ovf_q | |ovf;
    evt = |{pls_q, Ro_PLUS, Ro_MINUS, Ao_PLUS, Ao_MINUS};
    wd_d = (evt || TIMEOUT == 0) ? '0 : (wd_q == TO) ? wd_q : wd_q + 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pls_q <= '0;
      rr_q <= CH_AI;
      ro_q <= 1'b0;
      ao_q <= 1'b0;
      ovf_q <= 1'b0;
      out_q <= 1'b0;
      wd_q <= '0;
    end else begin
      pls_q <= pls_d;
      rr_q <= rr_d;
      ro_q <= ro_d;
      ao_q <= ao_d;
      ovf_q <= ovf_d;
      out_q <= out_d;
      wd_q <= wd_d;
    end
  assign {Ai_MINUS, Ai_PLUS, Ri_MINUS, Ri_PLUS} = pls_q;
  assign Ro = ro_q;
  assign Ao = ao_q;
  assign err_ovf = ovf_q;
  assign err_out = out_q;
  assign stall = (TIMEOUT != 0) && (wd_q == TO);
endmodule

// File: tb/tb_msfsm_event_scheduler.sv
// tb_msfsm_event_scheduler: scoreboard bench with directed vectors for msfsm_event_scheduler
module tb_msfsm_event_scheduler;
  logic clk = 0, reset = 1, Ri = 0, Ai = 0;
  logic Ro_PLUS = 0, Ro_MINUS = 0, Ao_PLUS = 0, Ao_MINUS = 0;
  logic Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS, Ro, Ao, err_ovf, err_out, stall;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct packed {logic [31:0] cyc; logic [3:0] code;} pexp_t;
  typedef struct packed {logic [31:0] cyc; logic [2:0] sig; logic val;} lexp_t;
  pexp_t pq[$], mpe;
  lexp_t lq[$], mle;
  logic [3:0] mp;
  logic [4:0] mlv;
  localparam logic [3:0] RP = 4'b0001, RM = 4'b0010, AP = 4'b0100, AM = 4'b1000;
  localparam int S_RO = 0, S_AO = 1, S_OVF = 2, S_OUT = 3, S_STALL = 4;
  msfsm_event_scheduler #(.SYNC_STAGES(2), .MAX_ISSUE(1), .TIMEOUT(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .Ri(Ri), .Ai(Ai),
    .Ri_PLUS(Ri_PLUS), .Ri_MINUS(Ri_MINUS), .Ai_PLUS(Ai_PLUS), .Ai_MINUS(Ai_MINUS),
    .Ro_PLUS(Ro_PLUS), .Ro_MINUS(Ro_MINUS), .Ao_PLUS(Ao_PLUS), .Ao_MINUS(Ao_MINUS),
    .Ro(Ro), .Ao(Ao), .err_ovf(err_ovf), .err_out(err_out), .stall(stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ep(input int c, input logic [3:0] code);
    pq.push_back('{c, code});
  endtask
  task automatic el(input int c, input int s, input logic v);
    lq.push_back('{c, s[2:0], v});
  endtask
  always @(negedge clk) begin
    mp = {Ai_MINUS, Ai_PLUS, Ri_MINUS, Ri_PLUS};
    while (pq.size() != 0 && int'(pq[0].cyc) < cyc) begin
      mpe = pq.pop_front();
      checks++;
      errors++;
      $display("FAIL pulse_missing: got none, expected %b at cyc %0d", mpe.code, mpe.cyc);
    end
    if (mp != 4'b0000) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got %b at cyc %0d, expected none", mp, cyc);
      end else begin
        mpe = pq.pop_front();
        if (mp != mpe.code || cyc != int'(mpe.cyc)) begin
          errors++;
          $display("FAIL pulse: got %b at cyc %0d, expected %b at cyc %0d", mp, cyc, mpe.code, mpe.cyc);
        end
      end
    end
    mlv = {stall, err_out, err_ovf, Ao, Ro};
    while (lq.size() != 0 && int'(lq[0].cyc) <= cyc) begin
      mle = lq.pop_front();
      checks++;
      if (mlv[mle.sig] !== mle.val) begin
        errors++;
        $display("FAIL level sig%0d at cyc %0d: got %b, expected %b", mle.sig, cyc, mlv[mle.sig], mle.val);
      end
    end
  end
  initial begin
    #20000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "bench timeout");
  end
  initial begin
    for (int s = 0; s < 5; s++) el(3, s, 1'b0);
    el(10, S_STALL, 0); el(11, S_STALL, 1); el(12, S_STALL, 1);
    el(13, S_STALL, 0); el(13, S_AO, 1); el(13, S_OUT, 0);
    el(46, S_OVF, 0); el(66, S_OVF, 0); el(76, S_OVF, 1);
    el(101, S_RO, 1); el(101, S_OUT, 0);
    el(104, S_RO, 1); el(104, S_OUT, 1); el(104, S_AO, 0);
    for (int s = 0; s < 5; s++) el(121, s, 1'b0);
    el(131, S_RO, 1); el(131, S_OUT, 0); el(134, S_RO, 1); el(134, S_OUT, 1);
    ep(24, RP); ep(34, RM); ep(44, RP); ep(45, RM); ep(54, RP); ep(55, AP);
    ep(64, RM); ep(74, AM); ep(75, RP); ep(76, RM); ep(84, RM); ep(94, AP);
    ep(95, RP); ep(110, AM); ep(111, RM); ep(125, RP); ep(126, AP);
    at(3); reset = 0;
    at(12); Ao_PLUS = 1;
    at(13); Ao_PLUS = 0;
    at(20); Ri = 1;
    at(30); Ri = 0;
    at(40); Ri = 1;
    at(41); Ri = 0;
    at(50); Ri = 1; Ai = 1;
    at(60); Ri = 0;
    at(70); Ai = 0; Ri = 1;
    at(71); Ri = 0;
    at(72); Ri = 1;
    at(80); Ri = 0;
    at(90); Ri = 1; Ai = 1;
    at(100); Ro_PLUS = 1;
    at(101); Ro_PLUS = 0;
    at(103); Ro_PLUS = 1; Ro_MINUS = 1; Ao_MINUS = 1;
    at(104); Ro_PLUS = 0; Ro_MINUS = 0; Ao_MINUS = 0;
    at(106); Ri = 0; Ai = 0;
    at(115); Ri = 1; Ai = 1;
    at(118); reset = 1;
    at(121); reset = 0;
    at(130); Ro_PLUS = 1;
    at(131); Ro_PLUS = 0;
    at(133); Ro_PLUS = 1;
    at(134); Ro_PLUS = 0;
    at(140);
    while (pq.size() != 0) begin
      mpe = pq.pop_front();
      checks++;
      errors++;
      $display("FAIL pulse_leftover: got none, expected %b at cyc %0d", mpe.code, mpe.cyc);
    end
    while (lq.size() != 0) begin
      mle = lq.pop_front();
      checks++;
      errors++;
      $display("FAIL level_leftover: got none, expected sig%0d=%b at cyc %0d", mle.sig, mle.val, mle.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
